// File: rtl/fix_rx_parser.sv
// Receive-side FIX framer: splits the inbound tag=value<SOH> byte stream into fields
// and checks BeginString/BodyLength ordering, BodyLength (9) and CheckSum (10).
//
// state   | meaning
// S_HUNT  | discarding bytes after an error until the next SOH
// S_TAG   | accumulating decimal tag digits up to '='
// S_VALUE | passing value bytes through until SOH closes the field
module fix_rx_parser #(
  parameter int TAG_W  = 16,
  parameter int BLEN_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        message_i,
  input  logic              valid_i,
  output logic [TAG_W-1:0]  tag_o,
  output logic [7:0]        value_o,
  output logic              value_valid_o,
  output logic              field_done_o,
  output logic [7:0]        msg_type_o,
  output logic              msg_done_o,
  output logic              len_err_o,
  output logic              cksum_err_o,
  output logic              format_err_o
);

  localparam logic [1:0] S_HUNT  = 2'd0;
  localparam logic [1:0] S_TAG   = 2'd1;
  localparam logic [1:0] S_VALUE = 2'd2;

  // position of the current field within the message
  localparam logic [1:0] F_BEGIN = 2'd0;
  localparam logic [1:0] F_BLEN  = 2'd1;
  localparam logic [1:0] F_BODY  = 2'd2;

  localparam logic [7:0] SOH = 8'h01;
  localparam logic [7:0] EQ  = 8'h3D;

  logic [1:0]        state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [TAG_W-1:0]  tag_acc_q, tag_acc_d;
  logic              tag_seen_q, tag_seen_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              val_seen_q, val_seen_d;
  logic [BLEN_W-1:0] blen_q, blen_d;
  logic [BLEN_W-1:0] bcnt_q, bcnt_d;
  logic [BLEN_W-1:0] bsnap_q, bsnap_d;
  logic [7:0]        sum_q, sum_d;
  logic [7:0]        ssnap_q, ssnap_d;
  logic [9:0]        ck_val_q, ck_val_d;
  logic [1:0]        ck_cnt_q, ck_cnt_d;
  logic              ck_bad_q, ck_bad_d;
  logic [7:0]        value_q, value_d;
  logic [7:0]        msg_type_q, msg_type_d;
  logic              value_valid_q, value_valid_d;
  logic              field_done_q, field_done_d;
  logic              msg_done_q, msg_done_d;
  logic              len_err_q, len_err_d;
  logic              cksum_err_q, cksum_err_d;
  logic              format_err_q, format_err_d;
  logic              fmt_err;

  logic              is_digit_w;
  logic              is_eq_w;
  logic              is_soh_w;
  logic [3:0]        digit_w;
  logic [TAG_W+3:0]  tag_mac_w;
  logic [TAG_W-1:0]  tag_sat_w;
  logic [BLEN_W+3:0] blen_mac_w;
  logic [BLEN_W-1:0] blen_sat_w;
  logic [BLEN_W-1:0] bcnt_inc_w;
  logic [9:0]        ck_mac_w;
  logic              order_ok_w;
  logic              ck_ok_w;
  logic              len_ok_w;

  assign is_digit_w = (message_i >= 8'h30) && (message_i <= 8'h39);
  assign is_eq_w    = (message_i == EQ);
  assign is_soh_w   = (message_i == SOH);
  assign digit_w    = message_i[3:0];

  assign tag_mac_w  = ({4'd0, tag_acc_q} * (TAG_W+4)'(10)) + (TAG_W+4)'(digit_w);
  assign tag_sat_w  = (|tag_mac_w[TAG_W+3:TAG_W]) ? {TAG_W{1'b1}} : tag_mac_w[TAG_W-1:0];
  assign blen_mac_w = ({4'd0, blen_q} * (BLEN_W+4)'(10)) + (BLEN_W+4)'(digit_w);
  assign blen_sat_w = (|blen_mac_w[BLEN_W+3:BLEN_W]) ? {BLEN_W{1'b1}} : blen_mac_w[BLEN_W-1:0];
  assign bcnt_inc_w = (&bcnt_q) ? bcnt_q : bcnt_q + BLEN_W'(1);
  assign ck_mac_w   = (ck_val_q * 10'd10) + {6'd0, digit_w};

  assign order_ok_w = (idx_q == F_BEGIN) ? (tag_acc_q == TAG_W'(8)) :
                      (idx_q == F_BLEN)  ? (tag_acc_q == TAG_W'(9)) : 1'b1;

  // snapshots were taken at the first tag byte of the CheckSum field
  assign ck_ok_w  = !ck_bad_q && (ck_cnt_q == 2'd3) && (ck_val_q <= 10'd255) &&
                    (ck_val_q[7:0] == ssnap_q);
  assign len_ok_w = (bsnap_q == blen_q);

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    tag_acc_d     = tag_acc_q;
    tag_seen_d    = tag_seen_q;
    tag_d         = tag_q;
    val_seen_d    = val_seen_q;
    blen_d        = blen_q;
    bcnt_d        = bcnt_q;
    bsnap_d       = bsnap_q;
    sum_d         = sum_q;
    ssnap_d       = ssnap_q;
    ck_val_d      = ck_val_q;
    ck_cnt_d      = ck_cnt_q;
    ck_bad_d      = ck_bad_q;
    value_d       = value_q;
    msg_type_d    = msg_type_q;
    value_valid_d = 1'b0;
    field_done_d  = 1'b0;
    msg_done_d    = 1'b0;
    len_err_d     = 1'b0;
    cksum_err_d   = 1'b0;
    format_err_d  = 1'b0;
    fmt_err       = 1'b0;

    if (valid_i) begin
      if (state_q != S_HUNT) begin
        sum_d  = sum_q + message_i;
        bcnt_d = bcnt_inc_w;
      end

      case (state_q)
        S_HUNT: begin
          if (is_soh_w) begin
            state_d = S_TAG;
            idx_d   = F_BEGIN;
            sum_d   = '0;
            bcnt_d  = '0;
          end
        end

        S_TAG: begin
          if (!tag_seen_q) begin
            ssnap_d = sum_q;
            bsnap_d = bcnt_q;
          end
          if (is_digit_w) begin
            tag_acc_d  = tag_sat_w;
            tag_seen_d = 1'b1;
          end else if (is_eq_w && tag_seen_q && order_ok_w) begin
            state_d    = S_VALUE;
            tag_d      = tag_acc_q;
            tag_acc_d  = '0;
            tag_seen_d = 1'b0;
            val_seen_d = 1'b0;
            ck_val_d   = '0;
            ck_cnt_d   = '0;
            ck_bad_d   = 1'b0;
            if (idx_q == F_BLEN) begin
              blen_d = '0;
            end
          end else begin
            fmt_err = 1'b1;
          end
        end

        S_VALUE: begin
          if (is_soh_w) begin
            if (!val_seen_q) begin
              fmt_err = 1'b1;
            end else begin
              field_done_d = 1'b1;
              state_d      = S_TAG;
              case (idx_q)
                F_BEGIN: idx_d = F_BLEN;
                F_BLEN: begin
                  idx_d  = F_BODY;
                  bcnt_d = '0;
                end
                default: begin
                  if (tag_q == TAG_W'(10)) begin
                    msg_done_d  = ck_ok_w && len_ok_w;
                    len_err_d   = !len_ok_w;
                    cksum_err_d = !ck_ok_w;
                    idx_d       = F_BEGIN;
                    sum_d       = '0;
                    bcnt_d      = '0;
                  end
                end
              endcase
            end
          end else if ((idx_q == F_BLEN) && !is_digit_w) begin
            fmt_err = 1'b1;
          end else begin
            val_seen_d    = 1'b1;
            value_d       = message_i;
            value_valid_d = 1'b1;
            if (idx_q == F_BLEN) begin
              blen_d = blen_sat_w;
            end
            if ((idx_q == F_BODY) && (tag_q == TAG_W'(35)) && !val_seen_q) begin
              msg_type_d = message_i;
            end
            if ((idx_q == F_BODY) && (tag_q == TAG_W'(10))) begin
              if (!is_digit_w || (ck_cnt_q == 2'd3)) begin
                ck_bad_d = 1'b1;
              end else begin
                ck_val_d = ck_mac_w;
                ck_cnt_d = ck_cnt_q + 2'd1;
              end
            end
          end
        end

        default: state_d = S_HUNT;
      endcase
    end

    if (fmt_err) begin
      format_err_d = 1'b1;
      state_d      = S_HUNT;
      tag_acc_d    = '0;
      tag_seen_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_TAG;
      idx_q         <= F_BEGIN;
      tag_acc_q     <= '0;
      tag_seen_q    <= 1'b0;
      tag_q         <= '0;
      val_seen_q    <= 1'b0;
      blen_q        <= '0;
      bcnt_q        <= '0;
      bsnap_q       <= '0;
      sum_q         <= '0;
      ssnap_q       <= '0;
      ck_val_q      <= '0;
      ck_cnt_q      <= '0;
      ck_bad_q      <= 1'b0;
      value_q       <= '0;
      msg_type_q    <= '0;
      value_valid_q <= 1'b0;
      field_done_q  <= 1'b0;
      msg_done_q    <= 1'b0;
      len_err_q     <= 1'b0;
      cksum_err_q   <= 1'b0;
      format_err_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      tag_acc_q     <= tag_acc_d;
      tag_seen_q    <= tag_seen_d;
      tag_q         <= tag_d;
      val_seen_q    <= val_seen_d;
      blen_q        <= blen_d;
      bcnt_q        <= bcnt_d;
      bsnap_q       <= bsnap_d;
      sum_q         <= sum_d;
      ssnap_q       <= ssnap_d;
      ck_val_q      <= ck_val_d;
      ck_cnt_q      <= ck_cnt_d;
      ck_bad_q      <= ck_bad_d;
      value_q       <= value_d;
      msg_type_q    <= msg_type_d;
      value_valid_q <= value_valid_d;
      field_done_q  <= field_done_d;
      msg_done_q    <= msg_done_d;
      len_err_q     <= len_err_d;
      cksum_err_q   <= cksum_err_d;
      format_err_q  <= format_err_d;
    end
  end

  assign tag_o         = tag_q;
  assign value_o       = value_q;
  assign value_valid_o = value_valid_q;
  assign field_done_o  = field_done_q;
  assign msg_type_o    = msg_type_q;
  assign msg_done_o    = msg_done_q;
  assign len_err_o     = len_err_q;
  assign cksum_err_o   = cksum_err_q;
  assign format_err_o  = format_err_q;

endmodule
